// File: rtl/cpu_mem_pkg.sv
// Shared memory-engine definitions: default geometry used by the CPU sequencer
// and the burst controller state encoding.
package cpu_mem_pkg;

  localparam int DEF_WORD_W    = 16;
  localparam int DEF_ADDR_W    = 12;
  localparam int DEF_MAX_BURST = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Top bit of word slot idx on an MSB-first packed bus.
  function automatic int slice_hi(input int idx, input int word_w, input int bus_w);
    return bus_w - 1 - idx * word_w;
  endfunction

endpackage

// File: rtl/ram_sp_sync.sv
// Single-port synchronous RAM, write-first, one-cycle registered read.
module ram_sp_sync #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata_q   <= wdata;
    end else begin
      rdata_q   <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst read/write engine in front of a synchronous word RAM, with range
// checking, error reporting and a level-based start/done handshake.
module ram_burst_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        read_start,
  input  logic                        write_start,
  input  logic [ADDR_W-1:0]           address,
  input  logic [15:0]                 count,
  input  logic [WORD_W*MAX_BURST-1:0] write_data,
  output logic [WORD_W*MAX_BURST-1:0] read_data,
  output logic                        done,
  output logic                        error,
  output logic                        busy
);

  localparam int BUS_W = WORD_W * MAX_BURST;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BUS_W-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;
  logic              err_q, err_d, op_rd_q, op_rd_d, op_wr_q, op_wr_d;

  logic [ADDR_W:0]   end_addr;
  logic              reject, start_seen, start_held;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata, ram_rdata;

  assign end_addr   = {1'b0, address} + (ADDR_W+1)'(count);
  assign reject     = (read_start & write_start) | (count > 16'(MAX_BURST)) | (end_addr > DEPTH);
  assign start_seen = read_start | write_start;
  assign start_held = (op_rd_q & read_start) | (op_wr_q & write_start);

  assign ram_addr = addr_q + ADDR_W'(cnt_q);
  assign ram_we   = (state_q == ST_WRITE) && (cnt_q != len_q) && !reset;

  always_comb begin
    ram_wdata = '0;
    for (int i = 0; i < MAX_BURST; i++) begin
      if (cnt_q == CNT_W'(i)) ram_wdata = wdata_q[slice_hi(i, WORD_W, BUS_W) -: WORD_W];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    op_rd_d = op_rd_q;
    op_wr_d = op_wr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_seen) begin
          addr_d  = address;
          wdata_d = write_data;
          op_rd_d = read_start;
          op_wr_d = write_start;
          cnt_d   = '0;
          err_d   = reject;
          // Rejected and empty requests take one zero-length WRITE pass so
          // done appears one edge after the request, with no RAM access.
          if (reject || count == '0) begin
            len_d   = '0;
            state_d = ST_WRITE;
          end else begin
            len_d = CNT_W'(count);
            if (read_start) begin
              rdata_d = '0;
              state_d = ST_READ;
            end else begin
              state_d = ST_WRITE;
            end
          end
        end
      end
      ST_READ: begin
        cnt_d = cnt_q + 1'b1;
        // RAM output now holds the word addressed in the previous cycle.
        for (int i = 0; i < MAX_BURST; i++) begin
          if (cnt_q == CNT_W'(i + 1)) rdata_d[slice_hi(i, WORD_W, BUS_W) -: WORD_W] = ram_rdata;
        end
        if (cnt_q == len_q) state_d = ST_DONE;
      end
      ST_WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == len_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!start_held) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      op_rd_q <= 1'b0;
      op_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      op_rd_q <= op_rd_d;
      op_wr_q <= op_wr_d;
    end
  end

  ram_sp_sync #(
    .WORD_W(WORD_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clock(clock),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign read_data = rdata_q;
  assign done      = (state_q == ST_DONE);
  assign error     = err_q & (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl: a word-array memory model and a timeline
// model of busy/done/error checked every cycle, plus literal pins.
module tb_ram_burst_ctrl;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         read_start = 1'b0;
  logic         write_start = 1'b0;
  logic [11:0]  address = '0;
  logic [15:0]  count = '0;
  logic [255:0] write_data = '0;
  logic [255:0] read_data;
  logic         done, error, busy;

  ram_burst_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .read_start (read_start),
    .write_start(write_start),
    .address    (address),
    .count      (count),
    .write_data (write_data),
    .read_data  (read_data),
    .done       (done),
    .error      (error),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // Model state: memory image and the timeline of the current request.
  logic [15:0]  mem_model [4096];
  logic [255:0] exp_rdata = '0;
  int           m_k = 0, m_tdone = 0, m_tend = 0;
  bit           m_rd = 1'b0, active = 1'b0, chk_en = 1'b0;
  logic         m_err = 1'b0;
  bit           exp_b, exp_d;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      exp_b = active && cyc >= m_k && cyc < m_tend;
      exp_d = active && cyc >= m_tdone && cyc < m_tend;
      chk("busy", {255'b0, busy}, {255'b0, exp_b});
      chk("done", {255'b0, done}, {255'b0, exp_d});
      if (exp_d) chk("error", {255'b0, error}, {255'b0, m_err});
      if (!(active && m_rd && cyc < m_tdone)) chk("read_data", read_data, exp_rdata);
    end
  end

  // Issue one request. hold = number of edges (from the sampling edge k) the
  // start stays high; rst_at > 0 asserts reset so it is sampled at edge k+rst_at.
  task automatic req(input bit rd, input bit wr, input int a, input int c,
                     input logic [255:0] wd, input int hold, input int rst_at,
                     output int lat, output int busy_n, output int done_n,
                     output logic err_seen);
    int k;
    int nwr;
    bit bad;
    k = cyc + 1;
    read_start  = rd;
    write_start = wr;
    address     = 12'(a);
    count       = 16'(c);
    write_data  = wd;
    bad = (rd && wr) || c > 16 || a + c > 4096;
    m_k   = k;
    m_rd  = 1'b0;
    m_err = bad;
    if (bad || c == 0) begin
      m_tdone = k + 1;
    end else begin
      m_tdone = k + c + 1;
      if (wr) begin
        nwr = (rst_at > 0) ? rst_at - 1 : c;
        for (int i = 0; i < nwr; i++) mem_model[a + i] = wd[255 - i*16 -: 16];
      end else begin
        m_rd = 1'b1;
        exp_rdata = '0;
        for (int i = 0; i < c; i++) exp_rdata[255 - i*16 -: 16] = mem_model[a + i];
      end
    end
    m_tend = (m_tdone + 1 > k + hold) ? m_tdone + 1 : k + hold;
    active = 1'b1;
    lat = -1;
    busy_n = 0;
    done_n = 0;
    err_seen = 1'bx;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      address    = 12'($urandom);
      count      = 16'($urandom_range(0, 20));
      write_data = {8{$urandom}};
      if (cyc + 1 >= k + hold) begin
        read_start  = 1'b0;
        write_start = 1'b0;
      end
      if (done === 1'b1) begin
        if (lat < 0) begin
          lat = cyc - k;
          err_seen = error;
        end
        done_n++;
      end else if (busy === 1'b1) begin
        busy_n++;
      end
      if (rst_at > 0 && cyc == k + rst_at - 1) reset = 1'b1;
      if (rst_at > 0 && cyc == k + rst_at) begin
        reset = 1'b0;
        read_start  = 1'b0;
        write_start = 1'b0;
        m_tend = cyc;
        exp_rdata = '0;
        chk("rst_busy", {255'b0, busy}, 256'd0);
        chk("rst_done", {255'b0, done}, 256'd0);
        break;
      end
      if (cyc >= m_tend) break;
    end
    read_start  = 1'b0;
    write_start = 1'b0;
    @(posedge clock);
    #1;
    $display("req rd=%0d wr=%0d addr=%03h cnt=%0d hold=%0d rst_at=%0d lat=%0d busy_n=%0d done_n=%0d err=%b",
             rd, wr, a, c, hold, rst_at, lat, busy_n, done_n, err_seen);
  endtask

  logic [255:0] wd;
  logic [255:0] full_lit;
  int           lat, bn, dn;
  logic         es;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    full_lit = 256'h0100_0101_0102_0103_0104_0105_0106_0107_0108_0109_010A_010B_010C_010D_010E_010F;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset_busy", {255'b0, busy}, 256'd0);
    chk("reset_done", {255'b0, done}, 256'd0);
    chk("reset_error", {255'b0, error}, 256'd0);
    chk("reset_rdata", read_data, 256'd0);
    exp_rdata = '0;
    chk_en = 1'b1;

    // Write then read 4 words at 16.
    wd = {16'h000C, 16'h0003, 16'h0005, 16'h0004, 192'h0};
    req(1, 0, 0, 0, '0, 1, 0, lat, bn, dn, es);  // warm-up: empty read
    chk("empty_rd_lat", lat, 1);
    req(0, 1, 16, 4, wd, 6, 0, lat, bn, dn, es);
    chk("wr4_lat", lat, 5);
    chk("wr4_err", {255'b0, es}, 256'd0);
    req(1, 0, 16, 4, '0, 6, 0, lat, bn, dn, es);
    chk("rd4_lat", lat, 5);
    chk("rd4_top", read_data[255:192], 64'h000C_0003_0005_0004);
    chk("rd4_rest", read_data[191:0], 192'h0);

    // Full 16-word burst.
    for (int i = 0; i < 16; i++) wd[255 - i*16 -: 16] = 16'h0100 + 16'(i);
    req(0, 1, 'h100, 16, wd, 18, 0, lat, bn, dn, es);
    chk("wr16_lat", lat, 17);
    req(1, 0, 'h100, 16, '0, 1, 0, lat, bn, dn, es);
    chk("rd16_lat", lat, 17);
    chk("rd16_busy", bn, 17);
    chk("rd16_data", read_data, full_lit);

    // Rejections.
    req(0, 1, 'h100, 17, {16{16'hFFFF}}, 1, 0, lat, bn, dn, es);
    chk("rej17_lat", lat, 1);
    chk("rej17_err", {255'b0, es}, 256'd1);
    req(1, 0, 'h100, 16, '0, 1, 0, lat, bn, dn, es);
    chk("rej17_mem", read_data, full_lit);
    req(1, 0, 'hFFE, 4, '0, 1, 0, lat, bn, dn, es);
    chk("rejrng_err", {255'b0, es}, 256'd1);
    chk("rejrng_lat", lat, 1);
    req(1, 1, 16, 4, '0, 1, 0, lat, bn, dn, es);
    chk("rejboth_err", {255'b0, es}, 256'd1);

    // Top-of-memory burst that just fits.
    wd = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 192'h0};
    req(0, 1, 'hFFC, 4, wd, 6, 0, lat, bn, dn, es);
    chk("edge_err", {255'b0, es}, 256'd0);
    req(1, 0, 'hFFC, 4, '0, 6, 0, lat, bn, dn, es);
    chk("edge_rd", read_data[255:192], 64'h1111_2222_3333_4444);

    // Empty write must not touch memory; single-word store/load.
    req(0, 1, 16, 0, {16{16'hFFFF}}, 1, 0, lat, bn, dn, es);
    chk("empty_lat", lat, 1);
    chk("empty_err", {255'b0, es}, 256'd0);
    req(1, 0, 16, 4, '0, 6, 0, lat, bn, dn, es);
    chk("empty_mem", read_data[255:192], 64'h000C_0003_0005_0004);
    req(0, 1, 5, 1, {16'hBEEF, 240'h0}, 3, 0, lat, bn, dn, es);
    chk("st1_lat", lat, 2);
    req(1, 0, 5, 1, '0, 3, 0, lat, bn, dn, es);
    chk("ld1_lat", lat, 2);
    chk("ld1_data", read_data, {16'hBEEF, 240'h0});

    // Handshake: start held long after done, and dropped mid-burst.
    req(0, 1, 32, 2, {16'h0A0A, 16'h0B0B, 224'h0}, 14, 0, lat, bn, dn, es);
    chk("hold_done_n", dn, 11);
    wd = {16'h00D1, 16'h00D2, 16'h00D3, 16'h00D4, 192'h0};
    req(0, 1, 48, 4, wd, 2, 0, lat, bn, dn, es);
    chk("drop_lat", lat, 5);
    chk("drop_done_n", dn, 1);
    req(1, 0, 48, 4, '0, 1, 0, lat, bn, dn, es);
    chk("drop_mem", read_data[255:192], 64'h00D1_00D2_00D3_00D4);

    // Reset in the middle of an 8-word write.
    for (int i = 0; i < 8; i++) wd[255 - i*16 -: 16] = 16'hA000 + 16'(i);
    wd[127:0] = '0;
    req(0, 1, 64, 8, wd, 10, 0, lat, bn, dn, es);
    for (int i = 0; i < 8; i++) wd[255 - i*16 -: 16] = 16'hB000 + 16'(i);
    req(0, 1, 64, 8, wd, 10, 3, lat, bn, dn, es);
    req(1, 0, 64, 8, '0, 10, 0, lat, bn, dn, es);
    chk("rst_mem", read_data, {16'hB000, 16'hB001, 16'hA002, 16'hA003,
                               16'hA004, 16'hA005, 16'hA006, 16'hA007, 128'h0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
